// File: rtl/tmds_decoder.sv
// TMDS lane decoder: finds symbol alignment from control tokens in a deserialized
// 10-bit stream, then decodes each aligned symbol to a data byte or control value.
module tmds_decoder #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_LIMIT = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [9:0] in_word,
    output logic       out_valid,
    output logic       out_de,
    output logic [1:0] out_ctl,
    output logic [7:0] out_data,
    output logic       locked,
    output logic [3:0] offset
);

    localparam logic [3:0]  LockCnt = 4'(LOCK_COUNT);
    localparam logic [15:0] LossLim = 16'(LOSS_LIMIT);

    typedef enum logic {StSearch, StLocked} state_t;

    state_t      state;
    logic [9:0]  prev;
    logic [3:0]  match_cnt;
    logic [3:0]  cand;
    logic [15:0] loss_cnt;

    logic [19:0] window;
    logic [9:0]  hit;
    logic        any_hit;
    logic [3:0]  hit_idx;
    logic [3:0]  match_next;
    logic [15:0] loss_next;
    logic [9:0]  sym;
    logic [2:0]  sym_tok;
    logic [7:0]  sym_data;

    // Returns {is_token, ctl}.
    function automatic logic [2:0] token_lookup(input logic [9:0] q);
        case (q)
            10'h354: return 3'b100;
            10'h0AB: return 3'b101;
            10'h154: return 3'b110;
            10'h2AB: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic is_token(input logic [9:0] q);
        return (q == 10'h354) || (q == 10'h0AB) || (q == 10'h154) || (q == 10'h2AB);
    endfunction

    function automatic logic [7:0] tmds_data(input logic [9:0] q);
        logic [7:0] dp;
        logic [7:0] d;
        dp   = q[9] ? ~q[7:0] : q[7:0];
        d    = '0;
        d[0] = dp[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (dp[i] ^ dp[i-1]) : ~(dp[i] ^ dp[i-1]);
        end
        return d;
    endfunction

    always_comb begin
        window = {in_word, prev};
        hit    = '0;
        for (int k = 0; k < 10; k++) begin
            hit[k] = is_token(window[k +: 10]);
        end
        any_hit = |hit;
        // Descending scan so the lowest matching offset wins.
        hit_idx = '0;
        for (int k = 9; k >= 0; k--) begin
            if (hit[k]) begin
                hit_idx = 4'(k);
            end
        end
        match_next = ((hit_idx == cand) && (match_cnt != 4'd0)) ? match_cnt + 4'd1 : 4'd1;
        loss_next  = loss_cnt + 16'd1;
        sym        = 10'(window >> offset);
        sym_tok    = token_lookup(sym);
        sym_data   = tmds_data(sym);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= StSearch;
            prev      <= '0;
            match_cnt <= '0;
            cand      <= '0;
            loss_cnt  <= '0;
            out_valid <= 1'b0;
            out_de    <= 1'b0;
            out_ctl   <= 2'b00;
            out_data  <= 8'h00;
            locked    <= 1'b0;
            offset    <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                prev <= in_word;
                unique case (state)
                    StSearch: begin
                        if (!any_hit) begin
                            match_cnt <= '0;
                        end else begin
                            cand      <= hit_idx;
                            match_cnt <= match_next;
                            if (match_next == LockCnt) begin
                                state    <= StLocked;
                                locked   <= 1'b1;
                                offset   <= hit_idx;
                                loss_cnt <= '0;
                            end
                        end
                    end
                    StLocked: begin
                        out_valid <= 1'b1;
                        if (sym_tok[2]) begin
                            out_de   <= 1'b0;
                            out_ctl  <= sym_tok[1:0];
                            out_data <= 8'h00;
                            loss_cnt <= '0;
                        end else begin
                            out_de   <= 1'b1;
                            out_data <= sym_data;
                            loss_cnt <= loss_next;
                            // The word that exhausts the budget is still emitted.
                            if (loss_next == LossLim) begin
                                state     <= StSearch;
                                locked    <= 1'b0;
                                match_cnt <= '0;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: directed alignment/decode/loss/reset scenarios followed by
// randomized traffic, every cycle compared against a behavioural reference model.
module tb_tmds_decoder;

    localparam int LockCount = 4;
    localparam int LossLimit = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [9:0] in_word = '0;
    logic       out_valid;
    logic       out_de;
    logic [1:0] out_ctl;
    logic [7:0] out_data;
    logic       locked;
    logic [3:0] offset;

    int checks = 0;
    int errors = 0;
    int gap_pct = 0;

    // Reference model state.
    int m_prev, m_lock, m_match, m_cand, m_loss, m_off;
    int e_valid, e_de, e_ctl, e_data;

    logic bq[$];

    always #5 clk = ~clk;

    tmds_decoder #(
        .LOCK_COUNT(LockCount),
        .LOSS_LIMIT(LossLimit)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_word  (in_word),
        .out_valid(out_valid),
        .out_de   (out_de),
        .out_ctl  (out_ctl),
        .out_data (out_data),
        .locked   (locked),
        .offset   (offset)
    );

    function automatic int tok_of(input int q);
        case (q)
            'h354:   return 0;
            'h0AB:   return 1;
            'h154:   return 2;
            'h2AB:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [9:0] token_sym(input int c);
        case (c)
            0:       return 10'h354;
            1:       return 10'h0AB;
            2:       return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    function automatic int decode(input int q);
        int dp;
        int d;
        int b;
        dp = ((q & 512) != 0) ? (~q & 255) : (q & 255);
        d  = dp & 1;
        for (int i = 1; i < 8; i++) begin
            b = ((dp >> i) ^ (dp >> (i - 1))) & 1;
            if ((q & 256) == 0) b = b ^ 1;
            d = d | (b << i);
        end
        return d;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] s;
        s = 10'($urandom);
        if (tok_of(int'(s)) >= 0) s = s ^ 10'h001;
        return s;
    endfunction

    task automatic model_update(input logic v, input logic [9:0] w, input logic rn);
        int win;
        int s;
        int t;
        int k;
        int cnt;
        if (!rn) begin
            m_prev = 0; m_lock = 0; m_match = 0; m_cand = 0; m_loss = 0; m_off = 0;
            e_valid = 0; e_de = 0; e_ctl = 0; e_data = 0;
        end else begin
            e_valid = 0;
            if (v) begin
                win = (int'(w) << 10) | m_prev;
                if (m_lock != 0) begin
                    s = (win >> m_off) & 1023;
                    t = tok_of(s);
                    e_valid = 1;
                    if (t >= 0) begin
                        e_de = 0; e_ctl = t; e_data = 0; m_loss = 0;
                    end else begin
                        e_de = 1; e_data = decode(s); m_loss = m_loss + 1;
                        if (m_loss == LossLimit) begin
                            m_lock = 0; m_match = 0;
                        end
                    end
                end else begin
                    k = -1;
                    for (int j = 9; j >= 0; j--) begin
                        if (tok_of((win >> j) & 1023) >= 0) k = j;
                    end
                    if (k < 0) begin
                        m_match = 0;
                    end else begin
                        cnt = (k == m_cand && m_match > 0) ? m_match + 1 : 1;
                        m_cand = k;
                        m_match = cnt;
                        if (cnt == LockCount) begin
                            m_lock = 1; m_off = k; m_loss = 0;
                        end
                    end
                end
                m_prev = int'(w);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [9:0] w, input logic rn);
        in_valid = v;
        in_word  = w;
        reset_n  = rn;
        @(posedge clk);
        model_update(v, w, rn);
        #1;
        chk("out_valid", {31'd0, out_valid}, e_valid);
        chk("out_de", {31'd0, out_de}, e_de);
        chk("out_ctl", {30'd0, out_ctl}, e_ctl);
        chk("out_data", {24'd0, out_data}, e_data);
        chk("locked", {31'd0, locked}, m_lock);
        chk("offset", {28'd0, offset}, m_off);
    endtask

    task automatic align(input int k);
        bq.delete();
        for (int i = 0; i < k; i++) bq.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic send_sym(input logic [9:0] s);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) bq.push_back(s[i]);
        while (bq.size() >= 10) begin
            for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
            if ($urandom_range(0, 99) < gap_pct) step(1'b0, 10'($urandom), 1'b1);
            step(1'b1, w, 1'b1);
        end
    endtask

    initial begin
        int r;
        model_update(1'b0, 10'h000, 1'b0);

        // Reset values.
        step(1'b0, 10'h000, 1'b0);
        step(1'b1, 10'h354, 1'b0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_offset", {28'd0, offset}, 0);
        chk("rst_out_ctl", {30'd0, out_ctl}, 0);
        chk("rst_out_data", {24'd0, out_data}, 0);

        // Aligned lock on repeated 0x354; output lags one word behind the window.
        align(0);
        for (int i = 0; i < 6; i++) send_sym(10'h354);
        chk("aligned_locked", {31'd0, locked}, 1);
        chk("aligned_offset", {28'd0, offset}, 0);
        chk("aligned_valid", {31'd0, out_valid}, 1);
        chk("aligned_de", {31'd0, out_de}, 0);
        chk("aligned_ctl", {30'd0, out_ctl}, 0);

        // Data decode.
        send_sym(10'h100);
        send_sym(10'h1FF);
        chk("dec_100", {24'd0, out_data}, 8'h00);
        chk("dec_100_de", {31'd0, out_de}, 1);
        send_sym(10'h2FF);
        chk("dec_1ff", {24'd0, out_data}, 8'h01);
        chk("dec_ctl_hold", {30'd0, out_ctl}, 0);
        send_sym(10'h354);
        chk("dec_2ff", {24'd0, out_data}, 8'hFE);
        send_sym(10'h0AB);
        send_sym(10'h354);
        chk("ctl_01", {30'd0, out_ctl}, 1);

        // Shifted lock at offset 3 with idle gaps.
        step(1'b1, 10'($urandom), 1'b0);
        gap_pct = 30;
        align(3);
        for (int i = 0; i < 12; i++) send_sym(10'h0AB);
        chk("shift_locked", {31'd0, locked}, 1);
        chk("shift_offset", {28'd0, offset}, 3);
        chk("shift_ctl", {30'd0, out_ctl}, 1);

        // Lock loss with LOSS_LIMIT=8.
        gap_pct = 0;
        for (int i = 0; i < 7; i++) send_sym(rand_data());
        send_sym(10'h0AB);
        send_sym(10'h0AB);
        chk("loss7_locked", {31'd0, locked}, 1);
        for (int i = 0; i < 8; i++) send_sym(rand_data());
        chk("loss7b_locked", {31'd0, locked}, 1);
        send_sym(rand_data());
        chk("loss8_unlocked", {31'd0, locked}, 0);
        chk("loss8_valid", {31'd0, out_valid}, 1);
        chk("loss8_de", {31'd0, out_de}, 1);

        // Search restart when the matching offset moves.
        step(1'b1, 10'($urandom), 1'b0);
        align(0);
        for (int i = 0; i < 3; i++) send_sym(10'h354);
        align(5);
        for (int i = 0; i < 4; i++) send_sym(10'h154);
        chk("search_no_lock", {31'd0, locked}, 0);
        send_sym(10'h154);
        send_sym(10'h154);
        chk("search_locked", {31'd0, locked}, 1);
        chk("search_offset", {28'd0, offset}, 5);

        // Reset while locked and streaming, then relock.
        send_sym(10'h154);
        step(1'b1, 10'($urandom), 1'b0);
        chk("midrst_valid", {31'd0, out_valid}, 0);
        chk("midrst_locked", {31'd0, locked}, 0);
        chk("midrst_offset", {28'd0, offset}, 0);
        chk("midrst_ctl", {30'd0, out_ctl}, 0);
        chk("midrst_de", {31'd0, out_de}, 0);
        for (int i = 0; i < 8; i++) send_sym(10'h154);
        chk("relock_locked", {31'd0, locked}, 1);
        chk("relock_offset", {28'd0, offset}, 5);

        // Randomized traffic.
        gap_pct = 20;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) step(1'b1, 10'($urandom), 1'b0);
            else if (r < 5) align($urandom_range(0, 9));
            else if (r < 55) send_sym(token_sym($urandom_range(0, 3)));
            else send_sym(rand_data());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
